// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use bubble insertion, flush and hold.
// Optional load-use stall counter output stall_cnt_o when ID_EX_STALL_CNT_EN is defined.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_uses_rt_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic              id_mem_read_i,
    input  logic              id_reg_write_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              exmem_reg_write_i,
    input  logic [4:0]        exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_reg_write_i,
    input  logic [4:0]        memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic              ex_mem_read_o,
    output logic              ex_reg_write_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_rd_o,
    output logic [DATA_W-1:0] ex_op_a_o,
    output logic [DATA_W-1:0] ex_op_b_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [CTRL_W-1:0] ex_ctrl_o
);

    logic              r_valid;
    logic              r_mem_read;
    logic              r_reg_write;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_imm;
    logic [CTRL_W-1:0] r_ctrl;

    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic              w_load_use;
    logic              w_bubble;

    // EX/MEM is the younger producer, so it is checked first; r0 is hard-wired zero.
    always_comb begin
        w_fwd_a = r_op_a;
        if (exmem_reg_write_i && (exmem_rd_i == r_rs) && (r_rs != 5'd0))
            w_fwd_a = exmem_data_i;
        else if (memwb_reg_write_i && (memwb_rd_i == r_rs) && (r_rs != 5'd0))
            w_fwd_a = memwb_data_i;

        w_fwd_b = r_op_b;
        if (exmem_reg_write_i && (exmem_rd_i == r_rt) && (r_rt != 5'd0))
            w_fwd_b = exmem_data_i;
        else if (memwb_reg_write_i && (memwb_rd_i == r_rt) && (r_rt != 5'd0))
            w_fwd_b = memwb_data_i;
    end

    assign w_load_use = r_valid && r_mem_read && r_reg_write && (r_rd != 5'd0) && id_valid_i &&
                        ((id_rs_i == r_rd) || (id_uses_rt_i && (id_rt_i == r_rd)));
    assign w_bubble   = flush_i || w_load_use;
    assign stall_o    = w_load_use || hold_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_reg_write <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_imm       <= '0;
            r_ctrl      <= '0;
        end else if (hold_i) begin
            // Capture bypass values now; their producers may retire before the hold releases.
            r_op_a <= w_fwd_a;
            r_op_b <= w_fwd_b;
        end else if (w_bubble) begin
            r_valid     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_reg_write <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_imm       <= '0;
            r_ctrl      <= '0;
        end else begin
            r_valid     <= id_valid_i;
            r_mem_read  <= id_valid_i && id_mem_read_i;
            r_reg_write <= id_valid_i && id_reg_write_i;
            r_rs        <= id_rs_i;
            r_rt        <= id_rt_i;
            r_rd        <= id_rd_i;
            r_op_a      <= id_rs_data_i;
            r_op_b      <= id_rt_data_i;
            r_imm       <= id_imm_i;
            r_ctrl      <= id_valid_i ? id_ctrl_i : '0;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (!hold_i && w_load_use)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

    assign ex_valid_o     = r_valid;
    assign ex_mem_read_o  = r_mem_read;
    assign ex_reg_write_o = r_reg_write;
    assign ex_rs_o        = r_rs;
    assign ex_rt_o        = r_rt;
    assign ex_rd_o        = r_rd;
    assign ex_op_a_o      = w_fwd_a;
    assign ex_op_b_o      = w_fwd_b;
    assign ex_imm_o       = r_imm;
    assign ex_ctrl_o      = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios then random traffic against a behavioural model.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_valid, id_uses_rt, id_mem_read, id_reg_write, flush, hold;
    logic          exmem_rw, memwb_rw;
    logic [4:0]    id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm, exmem_data, memwb_data;
    logic [CW-1:0] id_ctrl;

    logic          stall, ex_valid, ex_mr, ex_rw;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic [CW-1:0] ex_ctrl;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   m_cnt;
`endif

    id_ex_stage #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
        .id_uses_rt_i(id_uses_rt), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
        .id_imm_i(id_imm), .id_mem_read_i(id_mem_read), .id_reg_write_i(id_reg_write),
        .id_ctrl_i(id_ctrl), .flush_i(flush), .hold_i(hold),
        .exmem_reg_write_i(exmem_rw), .exmem_rd_i(exmem_rd), .exmem_data_i(exmem_data),
        .memwb_reg_write_i(memwb_rw), .memwb_rd_i(memwb_rd), .memwb_data_i(memwb_data),
`ifdef ID_EX_STALL_CNT_EN
        .stall_cnt_o(stall_cnt),
`endif
        .stall_o(stall), .ex_valid_o(ex_valid), .ex_mem_read_o(ex_mr), .ex_reg_write_o(ex_rw),
        .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
        .ex_op_a_o(ex_a), .ex_op_b_o(ex_b), .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl)
    );

    typedef struct packed {
        logic          v, mr, rw;
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] a, b, imm;
        logic [CW-1:0] ctrl;
    } ex_t;

    ex_t m, mn;
    int  n_chk = 0;
    int  n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Operand a producer would supply: youngest writer of a non-zero register, else the stored value.
    function automatic logic [DW-1:0] fwd(input logic [4:0] rn, input logic [DW-1:0] stored);
        if (rn != 5'd0 && exmem_rw && exmem_rd == rn) return exmem_data;
        if (rn != 5'd0 && memwb_rw && memwb_rd == rn) return memwb_data;
        return stored;
    endfunction

    function automatic logic lu();
        return m.v && m.mr && m.rw && (m.rd != 5'd0) && id_valid &&
               (id_rs == m.rd || (id_uses_rt && id_rt == m.rd));
    endfunction

    task automatic step();
        @(negedge clk);
        check("valid", ex_valid, m.v);
        check("mem_read", ex_mr, m.mr);
        check("reg_write", ex_rw, m.rw);
        check("rs", ex_rs, m.rs);
        check("rt", ex_rt, m.rt);
        check("rd", ex_rd, m.rd);
        check("op_a", ex_a, fwd(m.rs, m.a));
        check("op_b", ex_b, fwd(m.rt, m.b));
        check("imm", ex_imm, m.imm);
        check("ctrl", ex_ctrl, m.ctrl);
        check("stall", stall, lu() || hold);
`ifdef ID_EX_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_cnt);
        if (rst) m_cnt = 0;
        else if (!hold && lu()) m_cnt = m_cnt + 1;
`endif
        if (rst) mn = '0;
        else if (hold) begin
            mn = m;
            mn.a = fwd(m.rs, m.a);
            mn.b = fwd(m.rt, m.b);
        end else if (flush || lu()) mn = '0;
        else begin
            mn.v    = id_valid;
            mn.mr   = id_valid & id_mem_read;
            mn.rw   = id_valid & id_reg_write;
            mn.rs   = id_rs;
            mn.rt   = id_rt;
            mn.rd   = id_rd;
            mn.a    = id_rs_data;
            mn.b    = id_rt_data;
            mn.imm  = id_imm;
            mn.ctrl = id_valid ? id_ctrl : '0;
        end
        @(posedge clk);
        m = mn;
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_uses_rt = 0; id_mem_read = 0; id_reg_write = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_ctrl = 0;
        flush = 0; hold = 0; exmem_rw = 0; exmem_rd = 0; exmem_data = 0;
        memwb_rw = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        m = '0;
`ifdef ID_EX_STALL_CNT_EN
        m_cnt = 0;
`endif
        #1;
        step();
        check("reset_stall", stall, 0);
        rst = 0;

        // Plain capture
        id_valid = 1; id_rs = 3; id_rt = 4; id_rd = 9; id_uses_rt = 1; id_reg_write = 1;
        id_rs_data = 'h11; id_rt_data = 'h22; id_ctrl = 'h5A; id_imm = 'h100;
        step();
        check("cap_a", ex_a, 'h11);
        check("cap_b", ex_b, 'h22);
        check("cap_valid", ex_valid, 1);

        // Forward priority, then bypasses targeting r0
        id_rs = 5; id_rs_data = 'h77;
        step();
        idle();
        exmem_rw = 1; exmem_rd = 5; exmem_data = 'hAAAA;
        memwb_rw = 1; memwb_rd = 5; memwb_data = 'hBBBB;
        #1 check("fwd_priority", ex_a, 'hAAAA);
        exmem_rd = 0; memwb_rd = 0;
        #1 check("fwd_r0_stored", ex_a, 'h77);
        step();

        // Load-use: lw r7 then add r8,r7,r1
        idle();
        id_valid = 1; id_rs = 1; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
        step();
        idle();
        id_valid = 1; id_rs = 7; id_rt = 1; id_uses_rt = 1; id_rd = 8; id_reg_write = 1;
        #1 check("lu_stall", stall, 1);
        step();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_rw", ex_rw, 0);
        check("lu_stall_clear", stall, 0);
`ifdef ID_EX_STALL_CNT_EN
        check("lu_cnt", stall_cnt, 1);
`endif
        step();
        id_valid = 0;
        memwb_rw = 1; memwb_rd = 7; memwb_data = 'h1234;
        #1 check("lu_fwd_memwb", ex_a, 'h1234);
        check("lu_add_valid", ex_valid, 1);
        step();

        // Flush kills the entering instruction
        idle();
        id_valid = 1; id_rd = 4; id_reg_write = 1; id_ctrl = 'hFF; flush = 1;
        step();
        check("flush_valid", ex_valid, 0);
        check("flush_ctrl", ex_ctrl, 0);
`ifdef ID_EX_STALL_CNT_EN
        check("flush_cnt", stall_cnt, 1);
`endif

        // Hold with a retiring MEM/WB bypass and an ignored flush
        idle();
        id_valid = 1; id_rs = 6; id_rt = 2; id_rd = 3; id_uses_rt = 1; id_reg_write = 1; id_rt_data = 'h10;
        step();
        id_rd = 12; id_rs_data = 'hDEAD; hold = 1; flush = 1;
        memwb_rw = 1; memwb_rd = 2; memwb_data = 'h55;
        step();
        memwb_rw = 0;
        step();
        step();
        hold = 0; flush = 0; id_valid = 0;
        #1 check("hold_op_b", ex_b, 'h55);
        check("hold_rd", ex_rd, 3);
        check("hold_valid", ex_valid, 1);

        // Reset while holding
        hold = 1; rst = 1;
        step();
        check("rst_hold_valid", ex_valid, 0);
        rst = 0; hold = 0;

        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 49) == 0);
            hold         = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_uses_rt   = $urandom_range(0, 1);
            id_mem_read  = $urandom_range(0, 1);
            id_reg_write = $urandom_range(0, 3) != 0;
            id_rs        = 5'($urandom_range(0, 7));
            id_rt        = 5'($urandom_range(0, 7));
            id_rd        = 5'($urandom_range(0, 7));
            id_rs_data   = $urandom;
            id_rt_data   = $urandom;
            id_imm       = $urandom;
            id_ctrl      = 8'($urandom);
            exmem_rw     = $urandom_range(0, 1);
            exmem_rd     = 5'($urandom_range(0, 7));
            exmem_data   = $urandom;
            memwb_rw     = $urandom_range(0, 1);
            memwb_rd     = 5'($urandom_range(0, 7));
            memwb_data   = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core. It sits directly downstream of the register file. It captures the two register read operands plus decoded instruction fields each cycle, then presents forwarded operands to the ALU. It also detects load-use hazards, inserting a bubble and stalling PC/IF-ID, and honours flush and downstream hold requests.

## Interface
- `DATA_W`, 32: operand/immediate width
- `CTRL_W`, 8: opaque EX/MEM/WB control bundle width, passed through
- `clk_i` in 1: clock; all state updates on posedge
- `rst_i` in 1: synchronous, active-high reset
- `id_valid_i` in 1: ID holds a real instruction
- `id_rs_i`, `id_rt_i`, `id_rd_i` in 5: source/destination register numbers (`id_rd_i` is the final write target)
- `id_uses_rt_i` in 1: instruction reads rt as a source
- `id_rs_data_i`, `id_rt_data_i` in DATA_W: register file read data
- `id_imm_i` in DATA_W: sign/zero-extended immediate
- `id_mem_read_i`, `id_reg_write_i` in 1: load flag, write-back flag
- `id_ctrl_i` in CTRL_W: remaining control bits
- `flush_i` in 1: kill the instruction entering EX
- `hold_i` in 1: downstream busy, freeze stage
- `exmem_reg_write_i` in 1, `exmem_rd_i` in 5, `exmem_data_i` in DATA_W: EX/MEM bypass source
- `memwb_reg_write_i` in 1, `memwb_rd_i` in 5, `memwb_data_i` in DATA_W: MEM/WB bypass source
- `stall_o` out 1: freeze PC and IF/ID
- `ex_valid_o`, `ex_mem_read_o`, `ex_reg_write_o` out 1
- `ex_rs_o`, `ex_rt_o`, `ex_rd_o` out 5
- `ex_op_a_o`, `ex_op_b_o` out DATA_W: forwarded rs/rt operands
- `ex_imm_o` out DATA_W; `ex_ctrl_o` out CTRL_W

## Operation
- Registered state:
  - valid, rs/rt/rd numbers, stored operands A/B, imm, ctrl, mem_read, reg_write.
- Forwarding (combinational), for operand A on stored rs (same for B on stored rt):
  - Use `exmem_data_i` if `exmem_reg_write_i` and `exmem_rd_i` == rs != 0.
  - Else use `memwb_data_i` if `memwb_reg_write_i` and `memwb_rd_i` == rs != 0.
  - Else use the stored operand.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- Load-use is asserted when all of the following hold:
  - `ex_valid_o`, `ex_mem_read_o`, and `ex_reg_write_o` are set;
  - `ex_rd_o` != 0;
  - `id_valid_i` is set;
  - `id_rs_i` == `ex_rd_o`, or (`id_uses_rt_i` and `id_rt_i` == `ex_rd_o`).
- `stall_o` = load-use OR `hold_i`.
- Update priority per posedge, highest first:
  1. `rst_i`: all registered state cleared to 0.
  2. `hold_i`: all fields keep their values. Stored A/B are reloaded with the current forwarded `ex_op_a_o`/`ex_op_b_o`, so bypass values that retire during the hold are not lost. `flush_i` is ignored; upstream keeps it asserted.
  3. `flush_i` or load-use: insert a bubble. Valid, mem_read, reg_write and ctrl are set to 0; the other fields are don't-care and are zeroed.
  4. Otherwise, capture all ID inputs. Valid takes `id_valid_i`; mem_read/reg_write/ctrl are gated with `id_valid_i`.
- No write-through path from the register file is needed. Write-back occurs on negedge, so the ID read already reflects it.

## Timing
- One-cycle latency from ID inputs to registered `ex_*` outputs.
- `ex_op_a_o`, `ex_op_b_o` and `stall_o` are combinational from registered state and same-cycle inputs.
- Reset values: every registered output is 0, so `ex_op_a_o`/`ex_op_b_o` read 0 unless a bypass matches. `stall_o` equals `hold_i`.
- Load-use stall lasts exactly one cycle. The following cycle the load is in MEM and its result is forwarded from MEM/WB on the cycle after.
- `hold_i` on the same cycle as load-use: the hold wins. The load-use check repeats after the hold releases.
- Reset mid-hold or mid-stall: cleared on that posedge, with no residual bubble.

## Configuration
- `ID_EX_STALL_CNT_EN` defined:
  - Adds output `stall_cnt_o` [31:0].
  - Reset to 0; increments on every posedge where a load-use bubble is inserted (priority 3 via load-use, not flush).
  - Wraps from 0xFFFFFFFF to 0.
- `ID_EX_STALL_CNT_EN` undefined: the port and counter do not exist. Behaviour is otherwise identical.

## Test plan
- Reset: `rst_i`=1 for 2 cycles -> all `ex_*` = 0, `stall_o`=0, `stall_cnt_o`=0.
- Plain capture: rs=3 data 0x11, rt=4 data 0x22, no bypass matches -> next cycle `ex_op_a_o`=0x11, `ex_op_b_o`=0x22, `ex_valid_o`=1.
- Forward priority: EX rs=5; EX/MEM writes r5=0xAAAA and MEM/WB writes r5=0xBBBB -> `ex_op_a_o`=0xAAAA. Same scenario with rd=0 on both bypasses -> stored value is used.
- Load-use: `lw r7` in EX, then ID `add r8,r7,r1` -> `stall_o`=1 for one cycle and a bubble enters EX (`ex_valid_o`=0, `ex_reg_write_o`=0). `stall_cnt_o` becomes 1. Next cycle the add is captured, and `ex_op_a_o` takes the MEM/WB value 0x1234.
- Hold: `hold_i`=1 for 3 cycles while MEM/WB retires r2=0x55 matching EX rt -> `ex_*` fields are frozen and `ex_op_b_o`=0x55 after MEM/WB deasserts. A simultaneous `flush_i` is ignored.
- Flush: `flush_i`=1 with a valid ID instruction -> next cycle `ex_valid_o`=0 and ctrl=0; `stall_cnt_o` is unchanged.
